uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmit framer between NREQ strategy engines that each emit buy/sell decisions. Each requester owns a one-entry holding slot. A round-robin scheduler picks a pending slot, presents it on the framer's tx_addr/tx_buysell/tx_timestamp/tx_dv inputs, and tracks the framer's tx_busy line until that frame has been sent. Invalid decisions and overruns are counted, never forwarded.

## Interface
- NREQ, 4: number of requesters; range 2..8.
- TIMEOUT, 8: cycles to wait for tx_busy to rise after a tx_dv pulse before retrying.
- clk  in  1  system clock; the block uses this one clock only.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester decision strobe; one cycle per decision.
- req_addr  in  8*NREQ  instrument address; requester i uses bits [8i+7:8i].
- req_buysell  in  8*NREQ  decision code: 8'hF0 = BUY, 8'h0F = SELL.
- req_timestamp  in  32*NREQ  decision timestamp; requester i uses bits [32i+31:32i].
- req_ready  out  NREQ  slot i is empty.
- tx_dv  out  1  one-cycle strobe to the framer.
- tx_addr  out  8  frame address, held stable from the tx_dv cycle until the next issue.
- tx_buysell  out  8  frame decision code, held like tx_addr.
- tx_timestamp  out  32  frame timestamp, held like tx_addr.
- tx_busy  in  1  framer busy; high from the cycle after it accepts tx_dv until its stop byte is loaded.
- grant_id  out  3  index of the last requester issued.
- drop_cnt  out  16  saturating count of decisions that arrived while their slot was full.
- bad_cnt  out  16  saturating count of decisions with an invalid code.

## Operation
- Slot capture, for each i on every edge:
  - If req_valid[i] && req_ready[i] and the code is F0 or 0F: store addr/buysell/timestamp and set full[i].
  - If the code is invalid: no capture; bad_cnt increments.
  - If req_valid[i] && !req_ready[i]: no capture; drop_cnt increments.
- Counter updates:
  - Each counter adds the popcount of its events in the same cycle.
  - Each counter saturates at 16'hFFFF.
- req_ready[i] = !full[i], driven from registers.
- State machine: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: when any full[i] && !tx_busy:
  - Select the first full slot searching last_grant+1, +2, … modulo NREQ.
  - Load the tx_* outputs from that slot; tx_dv<=1; grant_id<=sel; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: tx_dv<=0; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 → WAIT_DONE.
  - Otherwise increment the timeout counter. On reaching TIMEOUT → IDLE with the slot still full (retry); last_grant is not updated.
- WAIT_DONE: on tx_busy=0, clear full[grant_id], set last_grant<=grant_id, go to IDLE.
- A slot cleared in WAIT_DONE cannot be recaptured in the same cycle, because req_ready was low. It can be recaptured from the next cycle.
- Only one frame is in flight at a time. tx_dv is never asserted while tx_busy=1 or outside IDLE→ISSUE.

## Timing
- Reset values:
  - state IDLE.
  - tx_dv 0.
  - tx_addr, tx_buysell, tx_timestamp 0.
  - all full[] 0, so req_ready all 1.
  - grant_id 0.
  - last_grant NREQ-1, so requester 0 wins first.
  - drop_cnt 0, bad_cnt 0.
- Reset asserted mid-frame discards every slot. The framer may still finish its current frame; the arbiter does not wait for it.
- Capture latency:
  - req_valid at edge n → req_ready low in cycle n+1.
  - Earliest tx_dv is in cycle n+1, registered at edge n+1 from IDLE.
- Framer turnaround:
  - tx_dv high for exactly one cycle, k.
  - tx_busy is expected by k+1; the timeout allows TIMEOUT cycles.
- Completion:
  - tx_busy falling edge seen in cycle m → req_ready[grant] high in m+1.
  - Next tx_dv no earlier than m+2.
- Simultaneous requests are all captured in one cycle and then served strictly in round-robin order. Each later frame waits for the previous frame's tx_busy to fall.

## Test plan
- Single request: req 0, addr 0x12, code F0, ts 0xDEADBEEF.
  - Expect one tx_dv pulse with those values, one cycle after capture.
  - Expect req_ready[0] low until the model's tx_busy falls, then high.
- Fairness: all 4 requesters valid in the same cycle, codes alternating F0/0F.
  - Expect grant order 0,1,2,3.
  - Re-load requester 0 and requester 2 while requester 3 is transmitting; expect 0 then 2.
- Overrun: requester 1 pulses three decisions while its slot is full.
  - Expect drop_cnt = 3; the first stored value is the one transmitted.
- Bad code: requester 2 sends code 0x55.
  - Expect no capture, bad_cnt = 1, no tx_dv.
- Timeout retry: the framer model ignores the first tx_dv.
  - Expect a second tx_dv with identical data, TIMEOUT+2 cycles after the first, and the slot kept.
- Reset mid-frame: assert reset_n=0 while in WAIT_DONE with two slots full.
  - Expect all outputs at their reset values and req_ready=4'hF.
  - After release, expect no tx_dv until a new req_valid.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester slot inputs and framer handshake.
// master = requesters + framer side, slave = arbiter side.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [8*NREQ-1:0]  req_addr;
  logic [8*NREQ-1:0]  req_buysell;
  logic [32*NREQ-1:0] req_timestamp;
  logic [NREQ-1:0]    req_ready;
  logic               tx_dv;
  logic [7:0]         tx_addr;
  logic [7:0]         tx_buysell;
  logic [31:0]        tx_timestamp;
  logic               tx_busy;

  modport master (
    output req_valid,
    output req_addr,
    output req_buysell,
    output req_timestamp,
    output tx_busy,
    input  req_ready,
    input  tx_dv,
    input  tx_addr,
    input  tx_buysell,
    input  tx_timestamp
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_buysell,
    input  req_timestamp,
    input  tx_busy,
    output req_ready,
    output tx_dv,
    output tx_addr,
    output tx_buysell,
    output tx_timestamp
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART framer
// between NREQ decision sources, one holding slot each.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_tx_arbiter_if.slave bus,
  output logic [2:0]       grant_id,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      bad_cnt
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t          state;
  logic [NREQ-1:0] full;
  logic [7:0]      addr_q [NREQ];
  logic [7:0]      code_q [NREQ];
  logic [31:0]     ts_q   [NREQ];
  logic [IW-1:0]   gid;
  logic [IW-1:0]   last_grant;
  logic [TW-1:0]   tcnt;

  logic [NREQ-1:0] cap_ev;
  logic [NREQ-1:0] drop_ev;
  logic [NREQ-1:0] bad_ev;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   idx;
  logic            sel_ok;

  function automatic logic code_ok(input logic [7:0] c);
    return (c == 8'hF0) || (c == 8'h0F);
  endfunction

  function automatic logic [15:0] sat_add(
    input logic [15:0]     c,
    input logic [NREQ-1:0] ev
  );
    logic [16:0] s;
    s = {1'b0, c} + 17'($countones(ev));
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    cap_ev  = '0;
    drop_ev = '0;
    bad_ev  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i]) begin
        bad_ev[i]  = !code_ok(bus.req_buysell[8*i +: 8]);
        drop_ev[i] = full[i];
        cap_ev[i]  = !full[i] && !bad_ev[i];
      end
    end
  end

  // Walk downwards so the nearest slot after last_grant wins.
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NREQ);
      if (full[idx]) begin
        sel    = idx;
        sel_ok = 1'b1;
      end
    end
  end

  assign bus.req_ready = ~full;
  assign grant_id      = 3'(gid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      full             <= '0;
      gid              <= '0;
      last_grant       <= IW'(NREQ - 1);
      tcnt             <= '0;
      drop_cnt         <= '0;
      bad_cnt          <= '0;
      bus.tx_dv        <= 1'b0;
      bus.tx_addr      <= '0;
      bus.tx_buysell   <= '0;
      bus.tx_timestamp <= '0;
      for (int i = 0; i < NREQ; i++) begin
        addr_q[i] <= '0;
        code_q[i] <= '0;
        ts_q[i]   <= '0;
      end
    end else begin
      drop_cnt <= sat_add(drop_cnt, drop_ev);
      bad_cnt  <= sat_add(bad_cnt, bad_ev);
      for (int i = 0; i < NREQ; i++) begin
        if (cap_ev[i]) begin
          full[i]   <= 1'b1;
          addr_q[i] <= bus.req_addr[8*i +: 8];
          code_q[i] <= bus.req_buysell[8*i +: 8];
          ts_q[i]   <= bus.req_timestamp[32*i +: 32];
        end
      end
      unique case (state)
        IDLE: begin
          if (sel_ok && !bus.tx_busy) begin
            bus.tx_addr      <= addr_q[sel];
            bus.tx_buysell   <= code_q[sel];
            bus.tx_timestamp <= ts_q[sel];
            bus.tx_dv        <= 1'b1;
            gid              <= sel;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          bus.tx_dv <= 1'b0;
          tcnt      <= '0;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
            // Framer never answered: drop back and reissue the same slot.
            if (int'(tcnt) + 1 >= TIMEOUT) state <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            full[gid]  <= 1'b0;
            last_grant <= gid;
            state      <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized rounds
// scored against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] t;
    logic [2:0]  g;
    int          c;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  grant_id;
  logic [15:0] drop_cnt;
  logic [15:0] bad_cnt;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .grant_id (grant_id),
    .drop_cnt (drop_cnt),
    .bad_cnt  (bad_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_len = 4;
  int ignore_cnt = 0;
  int busy_left = 0;
  int viol = 0;
  int m_last;
  int m_drop;
  int m_bad;
  frame_t frames[$];
  int falls[$];
  frame_t fr;

  always @(posedge clk) cyc++;

  // Framer model: busy from the negedge after tx_dv for busy_len cycles.
  always @(negedge clk) begin
    if (bus.tx_dv === 1'b1 && bus.tx_busy === 1'b1) viol++;
    if (bus.tx_dv === 1'b1) begin
      fr.a = bus.tx_addr;
      fr.b = bus.tx_buysell;
      fr.t = bus.tx_timestamp;
      fr.g = grant_id;
      fr.c = cyc;
      frames.push_back(fr);
      if (ignore_cnt > 0) ignore_cnt--;
      else busy_left = busy_len;
    end
    if (busy_left > 0) begin
      bus.tx_busy = 1'b1;
      busy_left--;
    end else begin
      if (bus.tx_busy === 1'b1) falls.push_back(cyc);
      bus.tx_busy = 1'b0;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a,
                         input logic [7:0] b, input logic [31:0] t);
    bus.req_valid[i]               = 1'b1;
    bus.req_addr[8*i +: 8]         = a;
    bus.req_buysell[8*i +: 8]      = b;
    bus.req_timestamp[32*i +: 32]  = t;
  endtask

  task automatic clr_req;
    bus.req_valid = '0;
  endtask

  task automatic do_reset;
    int k;
    clr_req();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    k = 0;
    while (bus.tx_busy === 1'b1 && k < 50) begin
      tick();
      k++;
    end
    tick();
    m_last = NREQ - 1;
    m_drop = 0;
    m_bad  = 0;
    frames.delete();
    falls.delete();
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (frames.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (frames.size() >= n);
  endtask

  task automatic wait_quiet(input string nm);
    int k;
    k = 0;
    while ((bus.tx_busy !== 1'b0 || bus.req_ready !== '1) && k < 400) begin
      tick();
      k++;
    end
    n_chk++;
    if (k >= 400) begin
      n_fail++;
      $display("FAIL %s quiet: busy=%b ready=%b want busy=0 ready=all1",
               nm, bus.tx_busy, bus.req_ready);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset;
    clr_req();
    bus.req_addr      = '0;
    bus.req_buysell   = '0;
    bus.req_timestamp = '0;
    bus.tx_busy       = 1'b0;
    reset_n           = 1'b0;
    repeat (2) tick();
    n_chk++;
    if (bus.req_ready !== '1) begin
      n_fail++;
      $display("FAIL reset ready: got %h want all ones", bus.req_ready);
    end
    n_chk++;
    if ({bus.tx_dv, bus.tx_addr, bus.tx_buysell, bus.tx_timestamp} !== '0) begin
      n_fail++;
      $display("FAIL reset tx: got dv=%b a=%h b=%h t=%h want 0",
               bus.tx_dv, bus.tx_addr, bus.tx_buysell, bus.tx_timestamp);
    end
    n_chk++;
    if ({grant_id, drop_cnt, bad_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset stat: got g=%0d d=%0d b=%0d want 0",
               grant_id, drop_cnt, bad_cnt);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    int cap;
    int k;
    bit ok;
    do_reset();
    set_req(0, 8'h12, 8'hF0, 32'hDEADBEEF);
    cap = cyc + 1;
    tick();
    clr_req();
    n_chk++;
    if (bus.req_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single ready after capture: got %b want 0", bus.req_ready[0]);
    end
    wait_frames(1, 20, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single no tx_dv: got %0d frames want 1", frames.size());
    end else begin
      n_chk++;
      if (frames[0].a !== 8'h12 || frames[0].b !== 8'hF0 ||
          frames[0].t !== 32'hDEADBEEF || frames[0].g !== 3'd0) begin
        n_fail++;
        $display("FAIL single data: got %h %h %h g%0d want 12 f0 deadbeef g0",
                 frames[0].a, frames[0].b, frames[0].t, frames[0].g);
      end
      n_chk++;
      if (frames[0].c != cap + 1) begin
        n_fail++;
        $display("FAIL single latency: got cycle %0d want %0d", frames[0].c, cap + 1);
      end
    end
    k = 0;
    while (falls.size() == 0 && k < 100) begin
      n_chk++;
      if (bus.req_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL single ready while busy: got %b want 0", bus.req_ready[0]);
      end
      tick();
      k++;
    end
    n_chk++;
    if (falls.size() == 0) begin
      n_fail++;
      $display("FAIL single busy fall: got none want one");
    end else begin
      n_chk++;
      if (bus.req_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL single ready at fall: got %b want 0", bus.req_ready[0]);
      end
      tick();
      n_chk++;
      if (bus.req_ready[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL single ready after fall: got %b want 1", bus.req_ready[0]);
      end
    end
    wait_quiet("single");
  endtask

  task automatic test_fairness;
    logic [7:0]  ea [NREQ];
    logic [7:0]  eb [NREQ];
    logic [31:0] et [NREQ];
    bit ok;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      ea[i] = 8'($urandom);
      eb[i] = (i % 2 == 1) ? 8'h0F : 8'hF0;
      et[i] = $urandom;
      set_req(i, ea[i], eb[i], et[i]);
    end
    tick();
    clr_req();
    n_chk++;
    if (bus.req_ready !== '0) begin
      n_fail++;
      $display("FAIL fair capture ready: got %h want 0", bus.req_ready);
    end
    wait_frames(NREQ, 300, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL fair frames: got %0d want %0d", frames.size(), NREQ);
    end else begin
      for (int j = 0; j < NREQ; j++) begin
        n_chk++;
        if (frames[j].g !== 3'(j) || frames[j].a !== ea[j] ||
            frames[j].b !== eb[j] || frames[j].t !== et[j]) begin
          n_fail++;
          $display("FAIL fair frame%0d: got g%0d %h %h %h want g%0d %h %h %h",
                   j, frames[j].g, frames[j].a, frames[j].b, frames[j].t,
                   j, ea[j], eb[j], et[j]);
        end
        if (j > 0 && falls.size() >= j) begin
          n_chk++;
          if (frames[j].c < falls[j-1] + 2) begin
            n_fail++;
            $display("FAIL fair spacing%0d: got cycle %0d want >= %0d",
                     j, frames[j].c, falls[j-1] + 2);
          end
        end
      end
    end
    ea[0] = 8'($urandom);
    et[0] = $urandom;
    ea[2] = 8'($urandom);
    et[2] = $urandom;
    set_req(0, ea[0], 8'hF0, et[0]);
    set_req(2, ea[2], 8'h0F, et[2]);
    tick();
    clr_req();
    wait_frames(NREQ + 2, 300, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL fair reload frames: got %0d want %0d", frames.size(), NREQ + 2);
    end else begin
      n_chk++;
      if (frames[NREQ].g !== 3'd0 || frames[NREQ].a !== ea[0] ||
          frames[NREQ].t !== et[0]) begin
        n_fail++;
        $display("FAIL fair reload first: got g%0d %h %h want g0 %h %h",
                 frames[NREQ].g, frames[NREQ].a, frames[NREQ].t, ea[0], et[0]);
      end
      n_chk++;
      if (frames[NREQ+1].g !== 3'd2 || frames[NREQ+1].b !== 8'h0F ||
          frames[NREQ+1].t !== et[2]) begin
        n_fail++;
        $display("FAIL fair reload second: got g%0d %h %h want g2 0f %h",
                 frames[NREQ+1].g, frames[NREQ+1].b, frames[NREQ+1].t, et[2]);
      end
    end
    wait_quiet("fair");
  endtask

  task automatic test_overrun;
    bit ok;
    do_reset();
    set_req(1, 8'h31, 8'hF0, 32'h11112222);
    tick();
    for (int j = 0; j < 3; j++) begin
      set_req(1, 8'(8'h40 + j), 8'h0F, $urandom);
      tick();
    end
    clr_req();
    n_chk++;
    if (drop_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL overrun drop_cnt: got %0d want 3", drop_cnt);
    end
    wait_frames(1, 30, ok);
    wait_quiet("overrun");
    n_chk++;
    if (frames.size() != 1) begin
      n_fail++;
      $display("FAIL overrun frame count: got %0d want 1", frames.size());
    end else begin
      n_chk++;
      if (frames[0].a !== 8'h31 || frames[0].b !== 8'hF0 ||
          frames[0].t !== 32'h11112222 || frames[0].g !== 3'd1) begin
        n_fail++;
        $display("FAIL overrun data: got %h %h %h g%0d want 31 f0 11112222 g1",
                 frames[0].a, frames[0].b, frames[0].t, frames[0].g);
      end
    end
  endtask

  task automatic test_bad_code;
    do_reset();
    set_req(2, 8'h77, 8'h55, 32'h55555555);
    tick();
    clr_req();
    n_chk++;
    if (bus.req_ready[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL bad ready: got %b want 1", bus.req_ready[2]);
    end
    n_chk++;
    if (bad_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL bad bad_cnt: got %0d want 1", bad_cnt);
    end
    repeat (20) tick();
    n_chk++;
    if (frames.size() != 0) begin
      n_fail++;
      $display("FAIL bad tx_dv: got %0d frames want 0", frames.size());
    end
  endtask

  task automatic test_timeout;
    bit ok;
    do_reset();
    ignore_cnt = 1;
    set_req(3, 8'hA5, 8'h0F, 32'hCAFEF00D);
    tick();
    clr_req();
    wait_frames(2, 80, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout retry: got %0d frames want 2", frames.size());
    end else begin
      n_chk++;
      if (bus.req_ready[3] !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout slot kept: got ready %b want 0", bus.req_ready[3]);
      end
      n_chk++;
      if (frames[1].c - frames[0].c != TIMEOUT + 2) begin
        n_fail++;
        $display("FAIL timeout gap: got %0d want %0d",
                 frames[1].c - frames[0].c, TIMEOUT + 2);
      end
      n_chk++;
      if (frames[1].a !== 8'hA5 || frames[1].b !== 8'h0F ||
          frames[1].t !== 32'hCAFEF00D || frames[1].g !== 3'd3 ||
          frames[0].a !== 8'hA5 || frames[0].t !== 32'hCAFEF00D) begin
        n_fail++;
        $display("FAIL timeout data: got %h/%h %h/%h g%0d want a5 cafef00d g3",
                 frames[0].a, frames[1].a, frames[0].t, frames[1].t, frames[1].g);
      end
    end
    wait_quiet("timeout");
    n_chk++;
    if (frames.size() != 2) begin
      n_fail++;
      $display("FAIL timeout extra frames: got %0d want 2", frames.size());
    end
    ignore_cnt = 0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_reset();
    busy_len = 8;
    set_req(0, 8'h01, 8'h33, 32'h0);
    set_req(1, 8'h9A, 8'hF0, 32'h89ABCDEF);
    set_req(2, 8'hBC, 8'h0F, 32'h01234567);
    tick();
    clr_req();
    set_req(1, 8'hEE, 8'hF0, 32'h0);
    tick();
    clr_req();
    wait_frames(1, 20, ok);
    repeat (3) tick();
    n_chk++;
    if (bus.tx_busy !== 1'b1 || grant_id !== 3'd1 || bus.tx_addr !== 8'h9A) begin
      n_fail++;
      $display("FAIL midreset precond: got busy=%b g%0d a=%h want 1 g1 9a",
               bus.tx_busy, grant_id, bus.tx_addr);
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (bus.req_ready !== '1) begin
      n_fail++;
      $display("FAIL midreset ready: got %h want all ones", bus.req_ready);
    end
    n_chk++;
    if ({bus.tx_dv, bus.tx_addr, bus.tx_buysell, bus.tx_timestamp} !== '0) begin
      n_fail++;
      $display("FAIL midreset tx: got dv=%b a=%h b=%h t=%h want 0",
               bus.tx_dv, bus.tx_addr, bus.tx_buysell, bus.tx_timestamp);
    end
    n_chk++;
    if ({grant_id, drop_cnt, bad_cnt} !== '0) begin
      n_fail++;
      $display("FAIL midreset stat: got g=%0d d=%0d b=%0d want 0",
               grant_id, drop_cnt, bad_cnt);
    end
    tick();
    reset_n = 1'b1;
    frames.delete();
    repeat (40) tick();
    n_chk++;
    if (frames.size() != 0) begin
      n_fail++;
      $display("FAIL midreset spurious tx_dv: got %0d want 0", frames.size());
    end
    busy_len = 4;
    set_req(3, 8'h33, 8'h0F, 32'h33333333);
    set_req(0, 8'h44, 8'hF0, 32'h44444444);
    tick();
    clr_req();
    wait_frames(2, 100, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midreset restart: got %0d frames want 2", frames.size());
    end else begin
      n_chk++;
      if (frames[0].g !== 3'd0 || frames[0].a !== 8'h44 || frames[1].g !== 3'd3) begin
        n_fail++;
        $display("FAIL midreset order: got g%0d a=%h then g%0d want g0 44 then g3",
                 frames[0].g, frames[0].a, frames[1].g);
      end
    end
    wait_quiet("midreset");
  endtask

  task automatic test_random;
    logic [7:0]      ea [NREQ];
    logic [7:0]      eb [NREQ];
    logic [31:0]     et [NREQ];
    logic [NREQ-1:0] cap;
    logic [7:0]      b;
    int              order[$];
    int              ov;
    bit              ok;
    do_reset();
    for (int r = 0; r < 30; r++) begin
      busy_len = $urandom_range(3, 6);
      cap = '0;
      order.delete();
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          ea[i] = 8'($urandom);
          et[i] = $urandom;
          if ($urandom_range(0, 4) != 0) begin
            b = ($urandom_range(0, 1) == 1) ? 8'hF0 : 8'h0F;
            cap[i] = 1'b1;
          end else begin
            b = 8'($urandom);
            if (b == 8'hF0 || b == 8'h0F) b = 8'h55;
            m_bad++;
          end
          eb[i] = b;
          set_req(i, ea[i], b, et[i]);
        end
      end
      tick();
      clr_req();
      if (cap != '0 && $urandom_range(0, 1) == 1) begin
        ov = $urandom_range(0, NREQ - 1);
        while (!cap[ov]) ov = (ov + 1) % NREQ;
        set_req(ov, 8'($urandom), 8'hF0, $urandom);
        m_drop++;
        tick();
        clr_req();
      end
      for (int k = 1; k <= NREQ; k++)
        if (cap[(m_last + k) % NREQ]) order.push_back((m_last + k) % NREQ);
      wait_frames(order.size(), 40 * NREQ + 40, ok);
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand%0d frames: got %0d want %0d", r, frames.size(), order.size());
      end
      wait_quiet("rand");
      n_chk++;
      if (frames.size() != order.size()) begin
        n_fail++;
        $display("FAIL rand%0d count: got %0d want %0d", r, frames.size(), order.size());
      end
      for (int j = 0; j < order.size() && j < frames.size(); j++) begin
        n_chk++;
        if (frames[j].g !== 3'(order[j]) || frames[j].a !== ea[order[j]] ||
            frames[j].b !== eb[order[j]] || frames[j].t !== et[order[j]]) begin
          n_fail++;
          $display("FAIL rand%0d frame%0d: got g%0d %h %h %h want g%0d %h %h %h",
                   r, j, frames[j].g, frames[j].a, frames[j].b, frames[j].t,
                   order[j], ea[order[j]], eb[order[j]], et[order[j]]);
        end
      end
      if (order.size() > 0) m_last = order[order.size() - 1];
      n_chk++;
      if (drop_cnt !== 16'(m_drop) || bad_cnt !== 16'(m_bad)) begin
        n_fail++;
        $display("FAIL rand%0d counters: got d=%0d b=%0d want d=%0d b=%0d",
                 r, drop_cnt, bad_cnt, m_drop, m_bad);
      end
      frames.delete();
      falls.delete();
    end
    busy_len = 4;
  endtask

  task automatic test_invariant;
    n_chk++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL tx_dv while busy: got %0d events want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_overrun();
    test_bad_code();
    test_timeout();
    test_reset_mid();
    test_random();
    test_invariant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
